instr_fetch_ctrl: RTL and testbench

Fetch sequencer for the single-port instruction memory. It owns the program counter and drives the memory address and read enable. It captures the returned instruction into a fetch/decode register and handles pipeline stall, branch/jump redirect, and HLT detection. It sits between the instruction memory and the decode stage and is the only master of the instruction memory port.

---
 rtl/instr_fetch_ctrl.sv | 96 +++++++++
 tb/tb_instr_fetch_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, drives the single-port instruction memory,
// captures fetched words for decode, and handles stall, redirect and HLT.
module instr_fetch_ctrl #(
    parameter logic [15:0] RESET_VEC = 16'h0000,
    parameter logic [3:0]  HLT_OPC   = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_tgt,
    input  logic [15:0] imem_instr,
    output logic [15:0] imem_addr,
    output logic        imem_rd_en,
    output logic [15:0] instr_out,
    output logic [15:0] pc_out,
    output logic        instr_vld,
    output logic        halted
);

    typedef enum logic [1:0] {StIdle, StFetch, StHalt} state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_out_q, pc_out_d;
    logic        vld_q, vld_d;
    logic        halted_q, halted_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            pc_q     <= RESET_VEC;
            instr_q  <= 16'h0000;
            pc_out_q <= 16'h0000;
            vld_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            vld_q    <= vld_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        vld_d    = vld_q;
        halted_d = halted_q;
        unique case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                if (branch_taken) begin
                    // Squash the word in flight; decode keeps its last instruction.
                    pc_d  = branch_tgt;
                    vld_d = 1'b0;
                end else if (!stall) begin
                    instr_d  = imem_instr;
                    pc_out_d = pc_q;
                    vld_d    = 1'b1;
                    if (imem_instr[15:12] == HLT_OPC) begin
                        state_d  = StHalt;
                        halted_d = 1'b1;
                    end else begin
                        pc_d = pc_q + 16'd1;
                    end
                end
            end
            StHalt: begin
                if (branch_taken) begin
                    // An older branch resolves: the HLT was speculative, so resume.
                    pc_d     = branch_tgt;
                    vld_d    = 1'b0;
                    halted_d = 1'b0;
                    state_d  = StFetch;
                end else if (!stall) begin
                    vld_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign imem_addr  = pc_q;
    assign imem_rd_en = (state_q == StFetch);
    assign instr_out  = instr_q;
    assign pc_out     = pc_out_q;
    assign instr_vld  = vld_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl; memory returns 0x1000+addr except an HLT word at 6.
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_tgt = 16'h0000;
    logic [15:0] imem_instr;
    logic [15:0] imem_addr;
    logic        imem_rd_en;
    logic [15:0] instr_out;
    logic [15:0] pc_out;
    logic        instr_vld;
    logic        halted;

    int checks = 0;
    int errors = 0;

    instr_fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_tgt   (branch_tgt),
        .imem_instr   (imem_instr),
        .imem_addr    (imem_addr),
        .imem_rd_en   (imem_rd_en),
        .instr_out    (instr_out),
        .pc_out       (pc_out),
        .instr_vld    (instr_vld),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    assign imem_instr = (imem_addr == 16'h0006) ? 16'hF000 : imem_addr + 16'h1000;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Packs {imem_addr, rd_en, pc_out, instr_out, vld, halted} for one comparison.
    function automatic logic [50:0] snap();
        return {imem_addr, imem_rd_en, pc_out, instr_out, instr_vld, halted};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (snap() !== {16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got %h want %h", snap(),
                     {16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0});
        end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        checks++;
        if (imem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_rd_en: got %b want 0", imem_rd_en);
        end
        step();  // edge 0: IDLE -> FETCH
        checks++;
        if ({imem_rd_en, instr_vld, imem_addr} !== {1'b1, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL edge0: got rd_en=%b vld=%b addr=%h want 1 0 0000",
                     imem_rd_en, instr_vld, imem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({pc_out, instr_out, instr_vld, imem_rd_en, imem_addr} !==
                {16'(i), 16'(16'h1000 + i), 1'b1, 1'b1, 16'(i + 1)}) begin
                errors++;
                $display("FAIL seq_%0d: got pc_out=%h instr=%h vld=%b rd_en=%b addr=%h",
                         i, pc_out, instr_out, instr_vld, imem_rd_en, imem_addr);
            end
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({pc_out, instr_out, instr_vld, imem_addr} !==
                {16'h0002, 16'h1002, 1'b1, 16'h0003}) begin
                errors++;
                $display("FAIL stall_hold_%0d: got pc_out=%h instr=%h vld=%b addr=%h",
                         i, pc_out, instr_out, instr_vld, imem_addr);
            end
        end
        stall = 1'b0;
        step();
        checks++;
        if ({pc_out, instr_out, imem_addr} !== {16'h0003, 16'h1003, 16'h0004}) begin
            errors++;
            $display("FAIL stall_release: got pc_out=%h instr=%h addr=%h want 0003 1003 0004",
                     pc_out, instr_out, imem_addr);
        end
        step();
    endtask

    task automatic test_branch();
        branch_taken = 1'b1;
        branch_tgt   = 16'h0040;
        step();
        checks++;
        if ({instr_vld, pc_out, instr_out, imem_addr} !==
            {1'b0, 16'h0004, 16'h1004, 16'h0040}) begin
            errors++;
            $display("FAIL branch_bubble: got vld=%b pc_out=%h instr=%h addr=%h",
                     instr_vld, pc_out, instr_out, imem_addr);
        end
        branch_taken = 1'b0;
        step();
        checks++;
        if ({instr_vld, pc_out, instr_out, imem_addr} !==
            {1'b1, 16'h0040, 16'h1040, 16'h0041}) begin
            errors++;
            $display("FAIL branch_target: got vld=%b pc_out=%h instr=%h addr=%h",
                     instr_vld, pc_out, instr_out, imem_addr);
        end
        branch_taken = 1'b1;
        stall        = 1'b1;
        branch_tgt   = 16'h0005;
        step();
        checks++;
        if ({instr_vld, imem_addr} !== {1'b0, 16'h0005}) begin
            errors++;
            $display("FAIL branch_over_stall: got vld=%b addr=%h want 0 0005",
                     instr_vld, imem_addr);
        end
        branch_taken = 1'b0;
        stall        = 1'b0;
        step();
        checks++;
        if ({instr_vld, pc_out, instr_out, imem_addr} !==
            {1'b1, 16'h0005, 16'h1005, 16'h0006}) begin
            errors++;
            $display("FAIL branch_stall_target: got vld=%b pc_out=%h instr=%h addr=%h",
                     instr_vld, pc_out, instr_out, imem_addr);
        end
    endtask

    task automatic test_hlt();
        step();
        checks++;
        if (snap() !== {16'h0006, 1'b0, 16'h0006, 16'hF000, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL hlt_capture: got %h want %h", snap(),
                     {16'h0006, 1'b0, 16'h0006, 16'hF000, 1'b1, 1'b1});
        end
        stall = 1'b1;
        step();
        checks++;
        if ({instr_vld, halted, imem_rd_en} !== 3'b110) begin
            errors++;
            $display("FAIL hlt_stall_hold: got vld=%b halted=%b rd_en=%b want 1 1 0",
                     instr_vld, halted, imem_rd_en);
        end
        stall = 1'b0;
        step();
        checks++;
        if (snap() !== {16'h0006, 1'b0, 16'h0006, 16'hF000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL hlt_drop_vld: got %h want %h", snap(),
                     {16'h0006, 1'b0, 16'h0006, 16'hF000, 1'b0, 1'b1});
        end
        step();
        checks++;
        if ({imem_addr, imem_rd_en, halted} !== {16'h0006, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL hlt_stays: got addr=%h rd_en=%b halted=%b want 0006 0 1",
                     imem_addr, imem_rd_en, halted);
        end
        branch_taken = 1'b1;
        branch_tgt   = 16'h0010;
        step();
        checks++;
        if ({halted, instr_vld, imem_rd_en, imem_addr} !== {1'b0, 1'b0, 1'b1, 16'h0010}) begin
            errors++;
            $display("FAIL hlt_unhalt: got halted=%b vld=%b rd_en=%b addr=%h",
                     halted, instr_vld, imem_rd_en, imem_addr);
        end
        branch_taken = 1'b0;
        step();
        checks++;
        if ({instr_vld, pc_out, instr_out} !== {1'b1, 16'h0010, 16'h1010}) begin
            errors++;
            $display("FAIL hlt_resume: got vld=%b pc_out=%h instr=%h want 1 0010 1010",
                     instr_vld, pc_out, instr_out);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_pc [3];
        exp_pc[0] = 16'hFFFE;
        exp_pc[1] = 16'hFFFF;
        exp_pc[2] = 16'h0000;
        branch_taken = 1'b1;
        branch_tgt   = 16'hFFFE;
        step();
        branch_taken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({instr_vld, pc_out, instr_out} !==
                {1'b1, exp_pc[i], 16'(exp_pc[i] + 16'h1000)}) begin
                errors++;
                $display("FAIL wrap_%0d: got vld=%b pc_out=%h instr=%h want pc_out=%h",
                         i, instr_vld, pc_out, instr_out, exp_pc[i]);
            end
        end
        checks++;
        if (imem_addr !== 16'h0001) begin
            errors++;
            $display("FAIL wrap_addr: got %h want 0001", imem_addr);
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (snap() !== {16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got %h want %h", snap(),
                     {16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0});
        end
        step();
        rst = 1'b0;
        checks++;
        if (imem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL restart_idle: got rd_en=%b want 0", imem_rd_en);
        end
        step();
        step();
        checks++;
        if ({instr_vld, pc_out, instr_out, imem_addr} !==
            {1'b1, 16'h0000, 16'h1000, 16'h0001}) begin
            errors++;
            $display("FAIL restart_first: got vld=%b pc_out=%h instr=%h addr=%h",
                     instr_vld, pc_out, instr_out, imem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_hlt();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
